// File: rtl/universal_shift_register.sv
// Parametrised universal shift register: parallel load, single-step shift/rotate,
// and an autonomous burst sequencer with busy/done handshake.
module universal_shift_register #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic [2:0]       op,
    input  logic             en,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic [2:0] OP_SHL = 3'b001;
    localparam logic [2:0] OP_SHR = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;
    localparam logic [2:0] OP_ASR = 3'b101;

    state_e           state_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [2:0]       op_q;
    logic [2:0]       step_op;
    logic [CNT_W-1:0] rem_q;
    logic             done_q;

    function automatic logic [WIDTH-1:0] step_f(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       o,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] r;
        case (o)
            OP_SHL:  r = {d[WIDTH-2:0], sr};
            OP_SHR:  r = {sl, d[WIDTH-1:1]};
            OP_ROL:  r = {d[WIDTH-2:0], d[WIDTH-1]};
            OP_ROR:  r = {d[0], d[WIDTH-1:1]};
            OP_ASR:  r = {d[WIDTH-1], d[WIDTH-1:1]};
            default: r = d;
        endcase
        return r;
    endfunction

    // A running burst uses its latched op; idle single steps use the live op.
    always_comb begin
        step_op = (state_q == SHIFT) ? op_q : op;
        data_d  = step_f(data_q, step_op, ser_in_l, ser_in_r);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            op_q    <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        data_q <= data_in;
                    end else if (start) begin
                        if (count != '0) begin
                            op_q    <= op;
                            rem_q   <= count;
                            state_q <= SHIFT;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end else if (en) begin
                        data_q <= data_d;
                    end
                end
                SHIFT: begin
                    if (load) begin
                        data_q  <= data_in;
                        rem_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        data_q <= data_d;
                        rem_q  <= rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out  = data_q;
    assign ser_out_l = data_q[WIDTH-1];
    assign ser_out_r = data_q[0];
    assign busy      = (state_q == SHIFT);
    assign done      = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register: directed scenarios with
// constant expectations plus randomized traffic against an arithmetic model.
module tb_universal_shift_register;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;
    localparam int MOD   = 1 << WIDTH;
    localparam int HALF  = MOD / 2;

    logic             clk;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic [2:0]       op;
    logic             en;
    logic             start;
    logic [CNT_W-1:0] count;
    logic             ser_in_l;
    logic             ser_in_r;
    logic [WIDTH-1:0] data_out;
    logic             ser_out_l;
    logic             ser_out_r;
    logic             busy;
    logic             done;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference model: integer register value plus pending burst length.
    int   m_val;
    int   m_left;
    int   m_op;
    logic m_done;

    universal_shift_register #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .data_in   (data_in),
        .op        (op),
        .en        (en),
        .start     (start),
        .count     (count),
        .ser_in_l  (ser_in_l),
        .ser_in_r  (ser_in_r),
        .data_out  (data_out),
        .ser_out_l (ser_out_l),
        .ser_out_r (ser_out_r),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int apply_op(input int v, input int o, input int sl, input int sr);
        case (o)
            1:       return (v * 2) % MOD + sr;
            2:       return v / 2 + sl * HALF;
            3:       return (v * 2) % MOD + v / HALF;
            4:       return v / 2 + (v % 2) * HALF;
            5:       return v / 2 + ((v >= HALF) ? HALF : 0);
            default: return v;
        endcase
    endfunction

    task automatic model_update();
        m_done = 1'b0;
        if (reset) begin
            m_val  = 0;
            m_left = 0;
            m_op   = 0;
        end else if (load) begin
            m_val  = int'(data_in);
            m_left = 0;
        end else if (m_left > 0) begin
            m_val  = apply_op(m_val, m_op, int'(ser_in_l), int'(ser_in_r));
            m_left = m_left - 1;
            if (m_left == 0) m_done = 1'b1;
        end else if (start) begin
            if (count == 0) m_done = 1'b1;
            else begin
                m_left = int'(count);
                m_op   = int'(op);
            end
        end else if (en) begin
            m_val = apply_op(m_val, int'(op), int'(ser_in_l), int'(ser_in_r));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; load = 1'b0; en = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        advance();
        advance();
        reset = 1'b0;
        chk_cnt++;
        if ({data_out, busy, done} !== 6'b0000_00)
            $display("FAIL reset_state: got data=%b busy=%b done=%b want 0000/0/0", data_out, busy, done);
        else pass_cnt++;
    endtask

    task automatic test_single_step();
        load = 1'b1; data_in = 4'b1010;
        advance();
        load = 1'b0;
        chk_cnt++;
        if (data_out !== 4'b1010) $display("FAIL load: got %b want 1010", data_out);
        else pass_cnt++;
        en = 1'b1; op = 3'b001; ser_in_r = 1'b0;
        advance();
        chk_cnt++;
        if (data_out !== 4'b0100) $display("FAIL step_shl: got %b want 0100", data_out);
        else pass_cnt++;
        op = 3'b010; ser_in_l = 1'b1;
        advance();
        en = 1'b0;
        chk_cnt++;
        if ({data_out, ser_out_l, ser_out_r} !== 6'b1010_10)
            $display("FAIL step_shr: got %b/%b%b want 1010/10", data_out, ser_out_l, ser_out_r);
        else pass_cnt++;
    endtask

    task automatic test_burst_rotate();
        logic [5:0] want [4];
        want[0] = 6'b0101_10; want[1] = 6'b1010_10; want[2] = 6'b0101_01; want[3] = 6'b0101_00;
        start = 1'b1; count = 3'd3; op = 3'b011;
        advance();
        start = 1'b0;
        chk_cnt++;
        if ({data_out, busy, done} !== 6'b1010_10)
            $display("FAIL rol_start_edge: got %b/%b%b want 1010/10", data_out, busy, done);
        else pass_cnt++;
        op = 3'b010;
        for (int i = 0; i < 4; i++) begin
            advance();
            chk_cnt++;
            if ({data_out, busy, done} !== want[i])
                $display("FAIL rol_burst_%0d: got %b want %b", i, {data_out, busy, done}, want[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_asr();
        load = 1'b1; data_in = 4'b1000;
        advance();
        load = 1'b0; start = 1'b1; count = 3'd2; op = 3'b101;
        advance();
        start = 1'b0;
        advance();
        chk_cnt++;
        if ({data_out, busy, done} !== 6'b1100_10)
            $display("FAIL asr_step1: got %b want 110010", {data_out, busy, done});
        else pass_cnt++;
        advance();
        chk_cnt++;
        if ({data_out, busy, done} !== 6'b1110_01)
            $display("FAIL asr_done: got %b want 111001", {data_out, busy, done});
        else pass_cnt++;
        op = 3'b111; en = 1'b1;
        advance();
        en = 1'b0;
        chk_cnt++;
        if ({data_out, busy, done} !== 6'b1110_00)
            $display("FAIL reserved_op: got %b want 111000", {data_out, busy, done});
        else pass_cnt++;
    endtask

    task automatic test_load_abort();
        load = 1'b1; data_in = 4'b1111;
        advance();
        load = 1'b0; start = 1'b1; count = 3'd7; op = 3'b001; ser_in_r = 1'b0;
        advance();
        start = 1'b0;
        advance();
        advance();
        chk_cnt++;
        if ({data_out, busy} !== 5'b1100_1)
            $display("FAIL abort_pre: got %b want 11001", {data_out, busy});
        else pass_cnt++;
        load = 1'b1; data_in = 4'b0110;
        advance();
        load = 1'b0;
        chk_cnt++;
        if ({data_out, busy, done} !== 6'b0110_00)
            $display("FAIL abort_load: got %b want 011000", {data_out, busy, done});
        else pass_cnt++;
        advance();
        chk_cnt++;
        if ({data_out, busy, done} !== 6'b0110_00)
            $display("FAIL abort_no_done: got %b want 011000", {data_out, busy, done});
        else pass_cnt++;
        en = 1'b1; op = 3'b001; ser_in_r = 1'b1;
        advance();
        en = 1'b0;
        chk_cnt++;
        if (data_out !== 4'b1101) $display("FAIL abort_then_en: got %b want 1101", data_out);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_and_zero();
        start = 1'b1; count = 3'd5; op = 3'b100;
        advance();
        start = 1'b0;
        advance();
        advance();
        reset = 1'b1;
        advance();
        reset = 1'b0;
        chk_cnt++;
        if ({data_out, busy, done} !== 6'b0000_00)
            $display("FAIL reset_mid_burst: got %b want 000000", {data_out, busy, done});
        else pass_cnt++;
        advance();
        chk_cnt++;
        if ({busy, done} !== 2'b00) $display("FAIL reset_no_done: got %b want 00", {busy, done});
        else pass_cnt++;
        load = 1'b1; data_in = 4'b1001;
        advance();
        load = 1'b0; start = 1'b1; count = 3'd0; op = 3'b011;
        advance();
        start = 1'b0;
        chk_cnt++;
        if ({data_out, busy, done} !== 6'b1001_01)
            $display("FAIL count_zero_done: got %b want 100101", {data_out, busy, done});
        else pass_cnt++;
        advance();
        chk_cnt++;
        if ({busy, done} !== 2'b00) $display("FAIL count_zero_pulse: got %b want 00", {busy, done});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        load = 1'b1; start = 1'b1; en = 1'b1; count = 3'd3; op = 3'b001; data_in = 4'b0011;
        advance();
        load = 1'b0; en = 1'b0;
        chk_cnt++;
        if ({data_out, busy, done} !== 6'b0011_00)
            $display("FAIL priority_load: got %b want 001100", {data_out, busy, done});
        else pass_cnt++;
        count = 3'd1; op = 3'b011;
        advance();
        start = 1'b0;
        advance();
        chk_cnt++;
        if ({data_out, busy, done} !== 6'b0110_01)
            $display("FAIL b2b_first_done: got %b want 011001", {data_out, busy, done});
        else pass_cnt++;
        start = 1'b1; count = 3'd2; op = 3'b100;
        advance();
        start = 1'b0;
        chk_cnt++;
        if ({data_out, busy, done} !== 6'b0110_10)
            $display("FAIL b2b_accept: got %b want 011010", {data_out, busy, done});
        else pass_cnt++;
        advance();
        advance();
        chk_cnt++;
        if ({data_out, busy, done} !== 6'b1001_01)
            $display("FAIL b2b_second_done: got %b want 100101", {data_out, busy, done});
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] mv;
        logic [WIDTH+3:0] exp_v;
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 59) == 0);
            load     = ($urandom_range(0, 19) == 0);
            start    = ($urandom_range(0, 5) == 0);
            en       = 1'($urandom_range(0, 1));
            op       = 3'($urandom_range(0, 7));
            count    = CNT_W'($urandom_range(0, (1 << CNT_W) - 1));
            data_in  = WIDTH'($urandom);
            ser_in_l = 1'($urandom_range(0, 1));
            ser_in_r = 1'($urandom_range(0, 1));
            advance();
            mv    = WIDTH'(m_val);
            exp_v = {mv, mv[WIDTH-1], mv[0], (m_left > 0), m_done};
            chk_cnt++;
            if ({data_out, ser_out_l, ser_out_r, busy, done} !== exp_v)
                $display("FAIL random_cycle_%0d: got %b want %b", i,
                         {data_out, ser_out_l, ser_out_r, busy, done}, exp_v);
            else pass_cnt++;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        data_in = '0; op = '0; count = '0; ser_in_l = 1'b0; ser_in_r = 1'b0;
        m_val = 0; m_left = 0; m_op = 0; m_done = 1'b0;
        test_reset();
        test_single_step();
        test_burst_rotate();
        test_asr();
        test_load_abort();
        test_reset_mid_and_zero();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
Parametrised universal shift register. It adds selectable shift/rotate modes, serial in/out at both ends, and a burst sequencer that performs N single-bit shifts autonomously with a busy/done handshake. It is the next-generation replacement for the fixed 4-bit load/shift register and sits in datapath and serialiser logic.

Parameters:
WIDTH, 4, register width in bits (>=2)
CNT_W, 3, width of burst count; max burst = 2^CNT_W-1 shifts

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
load  input  1  parallel load strobe
data_in  input  WIDTH  parallel load data
op  input  3  shift operation select (see Behaviour)
en  input  1  single-step shift enable (idle only)
start  input  1  begin burst of count shifts (idle only)
count  input  CNT_W  burst length, sampled with start
ser_in_l  input  1  serial bit entering MSB on right shift
ser_in_r  input  1  serial bit entering LSB on left shift
data_out  output  WIDTH  register contents
ser_out_l  output  1  equals data_out[WIDTH-1]
ser_out_r  output  1  equals data_out[0]
busy  output  1  burst in progress
done  output  1  one-cycle pulse at burst completion

Behaviour:
- Reset (synchronous, active-high, highest priority): data_out=0, busy=0, done=0, state=IDLE, latched op/count cleared. Reset mid-burst aborts immediately with no done pulse.
- op encoding; one step =
  - 000 HOLD: no change
  - 001 SHL: {d[W-2:0],ser_in_r}
  - 010 SHR: {ser_in_l,d[W-1:1]}
  - 011 ROL: {d[W-2:0],d[W-1]}
  - 100 ROR: {d[0],d[W-1:1]}
  - 101 ASR: {d[W-1],d[W-1:1]}
  - 110/111 reserved, treated as HOLD
- Priority in IDLE: reset > load > start > en.
- load: data_out<=data_in on that edge; any concurrent start/en is ignored.
- en in IDLE (no load/start): one step of live op on that edge.
- FSM states:
  - IDLE: busy=0.
    - start with count>0: latch op and count; go to SHIFT. No shift occurs on the start edge.
    - start with count==0: no shift, stay IDLE, done=1 for the next cycle.
  - SHIFT: busy=1. Each edge performs one step of the latched op and decrements the remaining count.
    - At remaining==1, that final step is taken, state goes to IDLE and done=1 for exactly the following cycle.
    - Live changes to op, count or start are ignored.
    - ser_in_l/ser_in_r are sampled live on each shift edge.
- Timing for start at edge k with count N>0:
  - busy is high after edges k..k+N-1.
  - Shifts occur on edges k+1..k+N.
  - Final data and done are visible after edge k+N.
  - busy=0 in the done cycle, so a new start is accepted in the done cycle.
- load while in SHIFT: aborts the burst. data_out<=data_in, state goes to IDLE, busy=0 next cycle, no done pulse.
- start or en while in SHIFT: ignored.
- count>WIDTH is legal:
  - rotates wrap;
  - SHL/SHR continue shifting in serial bits;
  - ASR saturates to all sign bits.
- done is a registered output. busy and done are never both high.
- ser_out_l/ser_out_r are combinational from data_out.

Test Plan:
- Reset then single steps (WIDTH=4): hold reset 2 cycles -> data_out=0000, busy=0, done=0. Release, load=1 data_in=1010 -> 1010. en=1 op=SHL ser_in_r=0 -> 0100; then op=SHR ser_in_l=1 -> 1010.
- Burst rotate: from 1010, start count=3 op=ROL -> data_out 1010 on the start edge, then 0101, 1010, 0101. busy high 3 cycles, then done high 1 cycle with busy=0. Changing op mid-burst has no effect.
- Arithmetic shift: load 1000, start count=2 op=ASR -> 1100 then 1110, done pulse. Reserved op=111 with en=1 -> unchanged.
- Load abort: from 1111, start count=7 op=SHL ser_in_r=0; after 2 shifts (1100) assert load data_in=0110 -> 0110, busy=0 next cycle, no done pulse, subsequent en works.
- Reset mid-burst and count=0: start count=5, assert reset after 2 shifts -> next cycle data_out=0000, busy=0, no done. Then start count=0 -> no shift, busy stays 0, done pulses 1 cycle.
- Priority and back-to-back: load=1 start=1 en=1 same edge -> load wins, busy=0. Issue start in the done cycle of a prior burst -> accepted, busy rises next cycle.
